// File: rtl/bit4_count.sv
// Free-running 4-bit binary counter with selectable modulus and direction.
// The count leaves the block on A (MSB) through D (LSB), straight from the register.
module bit4_count #(
  parameter int MODULUS  = 16,
  parameter bit COUNT_UP = 1'b1
) (
  input  logic clk,
  input  logic reset,
  output logic A,
  output logic B,
  output logic C,
  output logic D
);

  localparam logic [3:0] LAST = 4'(MODULUS - 1);
  localparam logic [4:0] MOD5 = 5'(MODULUS);

  logic [3:0] cnt;
  logic [3:0] cnt_next;

  // Any state at or beyond the modulus only arises from an upset; recover to zero.
  always_comb begin
    cnt_next = 4'd0;
    if ({1'b0, cnt} >= MOD5)
      cnt_next = 4'd0;
    else if (COUNT_UP)
      cnt_next = (cnt == LAST) ? 4'd0 : cnt + 4'd1;
    else
      cnt_next = (cnt == 4'd0) ? LAST : cnt - 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= 4'd0;
    else
      cnt <= cnt_next;
  end

  assign A = cnt[3];
  assign B = cnt[2];
  assign C = cnt[1];
  assign D = cnt[0];

endmodule

// File: tb/tb_bit4_count.sv
// Scoreboard bench for bit4_count: default up-counter, modulus-10 up-counter
// and 16-state down-counter run side by side from one clock and reset.
module tb_bit4_count;

  logic clk = 1'b0;
  logic reset;

  logic a_up, b_up, c_up, d_up;
  logic a_m10, b_m10, c_m10, d_m10;
  logic a_dn, b_dn, c_dn, d_dn;

  bit4_count #(.MODULUS(16), .COUNT_UP(1'b1)) dut_up (
    .clk(clk), .reset(reset), .A(a_up), .B(b_up), .C(c_up), .D(d_up)
  );

  bit4_count #(.MODULUS(10), .COUNT_UP(1'b1)) dut_m10 (
    .clk(clk), .reset(reset), .A(a_m10), .B(b_m10), .C(c_m10), .D(d_m10)
  );

  bit4_count #(.MODULUS(16), .COUNT_UP(1'b0)) dut_dn (
    .clk(clk), .reset(reset), .A(a_dn), .B(b_dn), .C(c_dn), .D(d_dn)
  );

  // Rising edges at 20, 60, 100, ... ns
  always #20 clk = ~clk;

  logic [11:0] obs;
  assign obs = {a_up, b_up, c_up, d_up, a_m10, b_m10, c_m10, d_m10, a_dn, b_dn, c_dn, d_dn};

  logic [11:0] exp_q[$];
  logic [11:0] exp_val;
  int n_compared   = 0;
  int n_mismatched = 0;
  int m_up, m_m10, m_dn;

  function automatic int next_val(input int cur, input int modulus, input bit up);
    if (cur >= modulus) return 0;
    if (up) return (cur == modulus - 1) ? 0 : cur + 1;
    return (cur == 0) ? modulus - 1 : cur - 1;
  endfunction

  function automatic logic [11:0] pack_models();
    return {4'(m_up), 4'(m_m10), 4'(m_dn)};
  endfunction

  task automatic clear_models();
    m_up  = 0;
    m_m10 = 0;
    m_dn  = 0;
    exp_q.push_back(pack_models());
  endtask

  task automatic advance();
    @(posedge clk);
    m_up  = next_val(m_up, 16, 1'b1);
    m_m10 = next_val(m_m10, 10, 1'b1);
    m_dn  = next_val(m_dn, 16, 1'b0);
    exp_q.push_back(pack_models());
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    clear_models();
    #4;
    exp_val = exp_q.pop_front();
    n_compared++;
    if (obs !== exp_val) begin
      n_mismatched++;
      $display("[TB] FAIL reset_state: got %b required %b", obs, exp_val);
    end
    #45 reset = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 7; i++) begin
      advance();
      #1;
      exp_val = exp_q.pop_front();
      n_compared++;
      if (obs !== exp_val) begin
        n_mismatched++;
        $display("[TB] FAIL pre_count_%0d: got %b required %b", i, obs, exp_val);
      end
    end
    // Now at 301 ns; pulse reset 320-330 with no clock edge inside the window.
    #19 reset = 1'b1;
    clear_models();
    #1;
    exp_val = exp_q.pop_front();
    n_compared++;
    if (obs !== exp_val) begin
      n_mismatched++;
      $display("[TB] FAIL async_clear: got %b required %b", obs, exp_val);
    end
    #9 reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      advance();
      #1;
      exp_val = exp_q.pop_front();
      n_compared++;
      if (obs !== exp_val) begin
        n_mismatched++;
        $display("[TB] FAIL release_count_%0d: got %b required %b", i, obs, exp_val);
      end
    end
  endtask

  task automatic test_simultaneous();
    @(posedge clk);
    reset = 1'b1;
    clear_models();
    exp_q.push_back(pack_models());
    #1;
    exp_val = exp_q.pop_front();
    n_compared++;
    if (obs !== exp_val) begin
      n_mismatched++;
      $display("[TB] FAIL reset_at_edge: got %b required %b", obs, exp_val);
    end
    #20;
    exp_val = exp_q.pop_front();
    n_compared++;
    if (obs !== exp_val) begin
      n_mismatched++;
      $display("[TB] FAIL reset_held: got %b required %b", obs, exp_val);
    end
    #9 reset = 1'b0;
  endtask

  task automatic test_full_sequence();
    for (int i = 1; i <= 17; i++) begin
      advance();
      #1;
      exp_val = exp_q.pop_front();
      n_compared++;
      if (obs !== exp_val) begin
        n_mismatched++;
        $display("[TB] FAIL seq_edge_%0d: got %b required %b", i, obs, exp_val);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    while (m_up != 10) advance();
    #1;
    while (exp_q.size() > 1) exp_val = exp_q.pop_front();
    exp_val = exp_q.pop_front();
    n_compared++;
    if (obs !== exp_val) begin
      n_mismatched++;
      $display("[TB] FAIL reach_1010: got %b required %b", obs, exp_val);
    end
    #5 reset = 1'b1;
    clear_models();
    #1;
    exp_val = exp_q.pop_front();
    n_compared++;
    if (obs !== exp_val) begin
      n_mismatched++;
      $display("[TB] FAIL mid_count_clear: got %b required %b", obs, exp_val);
    end
    #5 reset = 1'b0;
    advance();
    #1;
    exp_val = exp_q.pop_front();
    n_compared++;
    if (obs !== exp_val) begin
      n_mismatched++;
      $display("[TB] FAIL mid_count_resume: got %b required %b", obs, exp_val);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      advance();
      #1;
      exp_val = exp_q.pop_front();
      n_compared++;
      if (obs !== exp_val) begin
        n_mismatched++;
        $display("[TB] FAIL long_run_%0d: got %b required %b", i, obs, exp_val);
      end
    end
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_simultaneous();
    test_full_sequence();
    test_reset_mid_count();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
